alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-side initiator for the 4-bit ALU datapath. It accepts operation requests over a valid/ready handshake and drives the ALU operand and function lines, holding them stable. It captures the 8-bit ALU result and returns it over a second valid/ready handshake. It also keeps an 8-bit accumulator of the last add result, which can be fed back as operand B, and a completed-operation counter.

## Interface
- ALU_LATENCY, default 1: cycles the ALU inputs are held before the result is captured; legal range 1–15.
- ACC_INIT, default 8'h00: accumulator value after reset.

- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state at the next rising edge.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  sequencer can accept; high only in state IDLE.
- cmd_func  in  2  op code: 00 add, 01 OR-reduce, 10 AND-reduce, 11 concatenate.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_use_acc  in  1  replace cmd_b with acc[3:0].
- alu_a, alu_b  out  4 each  operands to the ALU.
- alu_func  out  2  function select to the ALU.
- alu_result  in  8  combinational ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  8  captured ALU result.
- rsp_func  out  2  op code of the response.
- acc  out  8  accumulator.
- op_count  out  8  completed responses, mod 256.
- err  out  1  sticky result-mismatch flag (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch into alu_a/alu_b/alu_func:
  - alu_a ← cmd_a; alu_func ← cmd_func.
  - alu_b ← cmd_use_acc ? acc[3:0] : cmd_b.
  - Clear the wait counter; go to EXEC.
- EXEC: alu_* are held constant. The wait counter increments each cycle. When it reaches ALU_LATENCY-1:
  - rsp_data ← alu_result; rsp_func ← alu_func.
  - If func==00, acc ← alu_result.
  - Go to RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_func stable. On rsp_valid&rsp_ready: op_count+1 (wraps 255→0); go to IDLE.
- cmd_valid outside IDLE is ignored. The requester holds the request until the handshake completes.
- The alu_* outputs keep their last values in IDLE and RESP.
- Result encoding expected from the ALU:
  - add: {3'b0, carry-out, 4-bit sum}.
  - OR: {7'b0, |{A,B}}.
  - AND: {7'b0, &{A,B}}.
  - concatenate: {A,B}.
- Reset at any state, including mid-EXEC or RESP, abandons the operation. No response is produced.

## Timing
- Reset values:
  - cmd_ready=0 while Reset is sampled high, 1 in the first cycle after.
  - rsp_valid=0, rsp_data=0, rsp_func=0, alu_a=alu_b=alu_func=0.
  - acc=ACC_INIT, op_count=0, err=0.
- Command accepted at edge k → capture at edge k+ALU_LATENCY → rsp_valid high from that edge.
- Response handshake at edge m → cmd_ready high from edge m.
- Peak throughput: one op per ALU_LATENCY+2 cycles (3 with the default).
- rsp_ready may be high before rsp_valid; the handshake completes on the first RESP edge.
- cmd_ready and rsp_valid are decoded from registered state only, with no input-to-output combinational paths.

## Configuration
- ALU_SEQ_CHECK_EN defined: an internal model computes the expected result from the latched alu_a/alu_b/alu_func. At the capture edge, a mismatch with alu_result sets err, which stays set until Reset.
- ALU_SEQ_CHECK_EN undefined: no model logic; err is tied to 0.

## Structure
- Shared package alu_seq_pkg:
  - alu_func_e enum: FN_ADD=2'b00, FN_OR=2'b01, FN_AND=2'b10, FN_CAT=2'b11.
  - FSM state enum.
  - Function expected_result(a, b, func), used by the checker and the bench.
- One sub-module, alu_seq_ref, holding the expected-result checker. It is instantiated only under ALU_SEQ_CHECK_EN.
- The wait counter and FSM stay in the top module.

## Test plan
- Add: A=4'h9, B=4'h8, func 00, accept at edge k → alu_b=4'h8 held, rsp_valid from edge k+1, rsp_data=8'h11, acc=8'h11, op_count=1.
- Reductions: OR A=0, B=0 → 8'h00; AND A=F, B=F → 8'h01; AND A=F, B=E → 8'h00. acc is unchanged in every case.
- Concatenate: A=4'h3, B=4'hC → rsp_data=8'h3C, rsp_func=11, acc unchanged.
- Accumulator feedback: after acc=8'h11, add A=4'h2, cmd_b=4'hF, use_acc=1 → alu_b=4'h1, rsp_data=8'h03, acc=8'h03.
- Backpressure: rsp_ready low for 5 cycles → rsp_valid, rsp_data, rsp_func stable; cmd_ready=0; a concurrent new cmd_valid is not accepted. After rsp_ready rises → cmd_ready=1 the next cycle.
- Reset mid-EXEC (ALU_LATENCY=4): reset at the 2nd EXEC cycle → no rsp_valid pulse, acc=ACC_INIT, op_count=0, cmd_ready=1 after reset. With ALU_SEQ_CHECK_EN, forcing alu_result=8'hFF for an add of 1+1 → err=1 and it stays set.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared function codes, FSM states and ALU result model for alu_sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {FN_ADD = 2'b00, FN_OR = 2'b01, FN_AND = 2'b10, FN_CAT = 2'b11} alu_func_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;
  function automatic logic [7:0] expected_result(input logic [3:0] a, input logic [3:0] b, input logic [1:0] func);
    logic [4:0] w_sum;
    w_sum = {1'b0, a} + {1'b0, b};
    return func == FN_ADD ? {3'b0, w_sum} :
           func == FN_OR  ? {7'b0, |{a, b}} :
           func == FN_AND ? {7'b0, &{a, b}} : {a, b};
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: command and response valid/ready handshakes of alu_sequencer
interface alu_seq_if;
  logic       cmd_valid, cmd_ready, cmd_use_acc, rsp_valid, rsp_ready;
  logic [1:0] cmd_func, rsp_func;
  logic [3:0] cmd_a, cmd_b;
  logic [7:0] rsp_data;
  modport master(output cmd_valid, cmd_func, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
                 input cmd_ready, rsp_valid, rsp_data, rsp_func);
  modport slave(input cmd_valid, cmd_func, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
                output cmd_ready, rsp_valid, rsp_data, rsp_func);
endinterface

// File: rtl/alu_seq_ref.sv
// alu_seq_ref: sticky mismatch flag comparing captured ALU results against the expected model
module alu_seq_ref
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cap,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [1:0] i_func,
  input  logic [7:0] i_result,
  output logic       o_err
);
  logic r_err;
  // set on any capture whose ALU result differs from the model; cleared only by reset
  always_ff @(posedge clk)
    r_err <= rst ? 1'b0 : r_err | (i_cap && i_result != expected_result(i_a, i_b, i_func));
  assign o_err = r_err;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: handshake-driven ALU initiator with accumulator and op counter; ALU_SEQ_CHECK_EN adds a result checker
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         ALU_LATENCY = 1,
  parameter logic [7:0] ACC_INIT    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [3:0] o_alu_a,
  output logic [3:0] o_alu_b,
  output logic [1:0] o_alu_func,
  input  logic [7:0] i_alu_result,
  output logic [7:0] o_acc,
  output logic [7:0] o_op_count,
  output logic       o_err
);
  state_e     r_state;
  logic [3:0] r_cnt, r_alu_a, r_alu_b;
  logic [1:0] r_alu_func, r_rsp_func;
  logic [7:0] r_rsp_data, r_acc, r_op_count;
  logic       r_cmd_ready, r_rsp_valid;
  logic       w_cap, w_err;
  assign w_cap = r_state == ST_EXEC && r_cnt == 4'(ALU_LATENCY - 1);
  // sequencing FSM; handshake outputs are registered alongside the state
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_func  <= '0;
      r_rsp_func  <= '0;
      r_rsp_data  <= '0;
      r_acc       <= ACC_INIT;
      r_op_count  <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else
      case (r_state)
        ST_IDLE:
          if (bus.cmd_valid && r_cmd_ready) begin
            r_alu_a     <= bus.cmd_a;
            r_alu_b     <= bus.cmd_use_acc ? r_acc[3:0] : bus.cmd_b;
            r_alu_func  <= bus.cmd_func;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end else r_cmd_ready <= 1'b1;
        ST_EXEC:
          if (w_cap) begin
            r_rsp_data  <= i_alu_result;
            r_rsp_func  <= r_alu_func;
            r_acc       <= r_alu_func == FN_ADD ? i_alu_result : r_acc;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else r_cnt <= r_cnt + 4'd1;
        ST_RESP:
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_op_count  <= r_op_count + 8'd1;
            r_state     <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
`ifdef ALU_SEQ_CHECK_EN
  alu_seq_ref u_ref (
    .clk      (clk),
    .rst      (rst),
    .i_cap    (w_cap),
    .i_a      (r_alu_a),
    .i_b      (r_alu_b),
    .i_func   (r_alu_func),
    .i_result (i_alu_result),
    .o_err    (w_err)
  );
`else
  assign w_err = 1'b0;
`endif
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_func  = r_rsp_func;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_func    = r_alu_func;
  assign o_acc         = r_acc;
  assign o_op_count    = r_op_count;
  assign o_err         = w_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checks of alu_sequencer against a behavioural model
module tb_alu_sequencer;
  logic clk = 0, rst = 1, rst_b = 1, force_ff = 0;
  always #5 clk = ~clk;
  alu_seq_if ifa ();
  alu_seq_if ifb ();
  logic [3:0] aa, ab, ba, bb;
  logic [1:0] af, bf;
  logic [7:0] ares, bres, aacc, bacc, acnt, bcnt;
  logic aerr, berr;
  int checks = 0, failures = 0;
  logic [7:0] macc_a = 8'h00, mcnt_a = 8'h00;
  localparam logic [7:0] INIT_B = 8'h5A;
`ifdef ALU_SEQ_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
    case (f)
      2'd0:    return 8'(int'(a) + int'(b));
      2'd1:    return (a != 0 || b != 0) ? 8'd1 : 8'd0;
      2'd2:    return (a == 4'hF && b == 4'hF) ? 8'd1 : 8'd0;
      default: return 8'(int'(a) * 16 + int'(b));
    endcase
  endfunction

  assign ares = alu_model(aa, ab, af);
  assign bres = force_ff ? 8'hFF : alu_model(ba, bb, bf);

  alu_sequencer u_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .o_alu_a(aa), .o_alu_b(ab), .o_alu_func(af),
    .i_alu_result(ares), .o_acc(aacc), .o_op_count(acnt), .o_err(aerr)
  );
  alu_sequencer #(.ALU_LATENCY(4), .ACC_INIT(INIT_B)) u_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave), .o_alu_a(ba), .o_alu_b(bb), .o_alu_func(bf),
    .i_alu_result(bres), .o_acc(bacc), .o_op_count(bcnt), .o_err(berr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; rst_b = 1;
    repeat (2) tick();
    checks++; if (ifa.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", ifa.cmd_ready); end
    checks++; if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_func, aa, ab, af} !== 21'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {ifa.rsp_valid, ifa.rsp_data, ifa.rsp_func, aa, ab, af}); end
    checks++; if ({aacc, acnt, aerr} !== 17'd0) begin failures++; $display("FAIL reset_acc_cnt_err got=%h exp=0", {aacc, acnt, aerr}); end
    checks++; if ({bacc, bcnt, berr} !== {INIT_B, 8'd0, 1'b0}) begin failures++; $display("FAIL reset_acc_init got=%h exp=%h", {bacc, bcnt, berr}, {INIT_B, 8'd0, 1'b0}); end
    rst = 0; rst_b = 0;
    tick();
    checks++; if ({ifa.cmd_ready, ifb.cmd_ready} !== 2'b11) begin failures++; $display("FAIL post_reset_cmd_ready got=%b exp=11", {ifa.cmd_ready, ifb.cmd_ready}); end
  endtask

  task automatic run_op(input logic [1:0] f, input logic [3:0] a, input logic [3:0] b, input logic u, input int dly);
    logic [3:0] eb;
    logic [7:0] er;
    int n;
    n = 0;
    while (!ifa.cmd_ready && n < 10) begin tick(); n++; end
    checks++; if (ifa.cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_wait got=%b exp=1", ifa.cmd_ready); end
    eb = u ? macc_a[3:0] : b;
    er = alu_model(a, eb, f);
    ifa.cmd_valid = 1; ifa.cmd_func = f; ifa.cmd_a = a; ifa.cmd_b = b; ifa.cmd_use_acc = u;
    ifa.rsp_ready = (dly == 0);
    tick();
    ifa.cmd_valid = 0;
    checks++; if ({ifa.cmd_ready, ifa.rsp_valid, aa, ab, af} !== {2'b00, a, eb, f}) begin failures++; $display("FAIL accept got=%h exp=%h", {ifa.cmd_ready, ifa.rsp_valid, aa, ab, af}, {2'b00, a, eb, f}); end
    tick();
    if (f == 2'd0) macc_a = er;
    checks++; if ({ifa.rsp_valid, ifa.rsp_data, ifa.rsp_func, aacc} !== {1'b1, er, f, macc_a}) begin failures++; $display("FAIL capture got=%h exp=%h", {ifa.rsp_valid, ifa.rsp_data, ifa.rsp_func, aacc}, {1'b1, er, f, macc_a}); end
    for (int i = 0; i < dly; i++) begin
      ifa.cmd_valid = 1; ifa.cmd_a = ~a; ifa.cmd_b = ~b; ifa.cmd_func = ~f;
      tick();
      checks++; if ({ifa.cmd_ready, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_func, aa, ab, af} !== {2'b01, er, f, a, eb, f}) begin failures++; $display("FAIL backpressure_hold got=%h exp=%h", {ifa.cmd_ready, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_func, aa, ab, af}, {2'b01, er, f, a, eb, f}); end
    end
    ifa.cmd_valid = 0; ifa.rsp_ready = 1;
    tick();
    mcnt_a++;
    checks++; if ({ifa.cmd_ready, ifa.rsp_valid, acnt, aacc, aa, ab, af} !== {2'b10, mcnt_a, macc_a, a, eb, f}) begin failures++; $display("FAIL complete got=%h exp=%h", {ifa.cmd_ready, ifa.rsp_valid, acnt, aacc, aa, ab, af}, {2'b10, mcnt_a, macc_a, a, eb, f}); end
    ifa.rsp_ready = 0;
  endtask

  task automatic test_directed;
    run_op(2'b00, 4'h9, 4'h8, 1'b0, 0);
    run_op(2'b01, 4'h0, 4'h0, 1'b0, 1);
    run_op(2'b10, 4'hF, 4'hF, 1'b0, 0);
    run_op(2'b10, 4'hF, 4'hE, 1'b0, 2);
    run_op(2'b11, 4'h3, 4'hC, 1'b0, 0);
    run_op(2'b00, 4'h2, 4'hF, 1'b1, 0);
    run_op(2'b00, 4'h5, 4'h1, 1'b0, 5);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic b_issue(input logic [3:0] a, input logic [3:0] b);
    ifb.cmd_valid = 1; ifb.cmd_func = 2'b00; ifb.cmd_a = a; ifb.cmd_b = b; ifb.cmd_use_acc = 0; ifb.rsp_ready = 1;
    tick();
    ifb.cmd_valid = 0;
  endtask

  task automatic test_latency4;
    checks++; if (ifb.cmd_ready !== 1'b1) begin failures++; $display("FAIL lat4_ready got=%b exp=1", ifb.cmd_ready); end
    b_issue(4'h7, 4'h9);
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (ifb.rsp_valid !== 1'b0) begin failures++; $display("FAIL lat4_early_valid cycle=%0d got=%b exp=0", i, ifb.rsp_valid); end
    end
    tick();
    checks++; if ({ifb.rsp_valid, ifb.rsp_data, bacc} !== {1'b1, 8'h10, 8'h10}) begin failures++; $display("FAIL lat4_capture got=%h exp=%h", {ifb.rsp_valid, ifb.rsp_data, bacc}, {1'b1, 8'h10, 8'h10}); end
    tick();
    checks++; if ({ifb.cmd_ready, ifb.rsp_valid, bcnt} !== {2'b10, 8'd1}) begin failures++; $display("FAIL lat4_complete got=%h exp=%h", {ifb.cmd_ready, ifb.rsp_valid, bcnt}, {2'b10, 8'd1}); end
  endtask

  task automatic test_reset_mid_exec;
    b_issue(4'h3, 4'h4);
    tick();
    rst_b = 1;
    tick();
    checks++; if ({ifb.cmd_ready, ifb.rsp_valid, bacc, bcnt, berr} !== {2'b00, INIT_B, 8'd0, 1'b0}) begin failures++; $display("FAIL mid_exec_reset got=%h exp=%h", {ifb.cmd_ready, ifb.rsp_valid, bacc, bcnt, berr}, {2'b00, INIT_B, 8'd0, 1'b0}); end
    rst_b = 0;
    tick();
    checks++; if (ifb.cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_exec_ready got=%b exp=1", ifb.cmd_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++; if ({ifb.rsp_valid, bcnt, bacc} !== {1'b0, 8'd0, INIT_B}) begin failures++; $display("FAIL mid_exec_no_rsp cycle=%0d got=%h exp=%h", i, {ifb.rsp_valid, bcnt, bacc}, {1'b0, 8'd0, INIT_B}); end
      tick();
    end
  endtask

  task automatic test_check_err;
    force_ff = 1;
    b_issue(4'h1, 4'h1);
    repeat (4) tick();
    checks++; if ({ifb.rsp_valid, ifb.rsp_data, bacc, berr} !== {1'b1, 8'hFF, 8'hFF, EXP_ERR}) begin failures++; $display("FAIL err_set got=%h exp=%h", {ifb.rsp_valid, ifb.rsp_data, bacc, berr}, {1'b1, 8'hFF, 8'hFF, EXP_ERR}); end
    tick();
    force_ff = 0;
    b_issue(4'h2, 4'h2);
    repeat (4) tick();
    checks++; if ({ifb.rsp_valid, ifb.rsp_data, berr} !== {1'b1, 8'h04, EXP_ERR}) begin failures++; $display("FAIL err_sticky got=%h exp=%h", {ifb.rsp_valid, ifb.rsp_data, berr}, {1'b1, 8'h04, EXP_ERR}); end
    tick();
    rst_b = 1;
    tick();
    rst_b = 0;
    checks++; if (berr !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", berr); end
  endtask

  initial begin
    ifa.cmd_valid = 0; ifa.cmd_func = 0; ifa.cmd_a = 0; ifa.cmd_b = 0; ifa.cmd_use_acc = 0; ifa.rsp_ready = 0;
    ifb.cmd_valid = 0; ifb.cmd_func = 0; ifb.cmd_a = 0; ifb.cmd_b = 0; ifb.cmd_use_acc = 0; ifb.rsp_ready = 0;
    test_reset();
    test_directed();
    test_random();
    test_latency4();
    test_reset_mid_exec();
    test_check_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
